// File: rtl/mcu_scheduler_pkg.sv
// Shared types and constants for the MCU block scheduler.
package mcu_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_RESTART,
    ST_DCCLR,
    ST_DONE
  } sched_state_e;

  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_444  = 2'd1,
    MODE_422  = 2'd2,
    MODE_420  = 2'd3
  } samp_mode_e;

  localparam int MAX_BLK_PER_MCU = 6;
  localparam int BLK_IDX_W       = $clog2(MAX_BLK_PER_MCU);

  function automatic logic [BLK_IDX_W-1:0] blocks_per_mcu(input samp_mode_e mode);
    case (mode)
      MODE_GRAY: blocks_per_mcu = BLK_IDX_W'(1);
      MODE_444:  blocks_per_mcu = BLK_IDX_W'(3);
      MODE_422:  blocks_per_mcu = BLK_IDX_W'(4);
      default:   blocks_per_mcu = BLK_IDX_W'(6);
    endcase
  endfunction

endpackage

// File: rtl/mcu_order_lut.sv
// Maps (sampling mode, block index) to the colour component and MCU block count.
module mcu_order_lut
  import mcu_scheduler_pkg::*;
#(
  parameter int CH_W = 2
) (
  input  samp_mode_e             mode,
  input  logic [BLK_IDX_W-1:0]   blk_idx,
  output logic [CH_W-1:0]        ch,
  output logic [BLK_IDX_W-1:0]   nblk,
  output logic                   last_blk
);

  localparam logic [CH_W-1:0] CH_Y  = CH_W'(0);
  localparam logic [CH_W-1:0] CH_CB = CH_W'(1);
  localparam logic [CH_W-1:0] CH_CR = CH_W'(2);

  always_comb begin
    ch   = CH_Y;
    nblk = blocks_per_mcu(mode);
    // Luma blocks always lead the MCU; the two chroma blocks close it.
    case (mode)
      MODE_444: begin
        case (blk_idx)
          BLK_IDX_W'(1): ch = CH_CB;
          BLK_IDX_W'(2): ch = CH_CR;
          default:       ch = CH_Y;
        endcase
      end
      MODE_422: begin
        case (blk_idx)
          BLK_IDX_W'(2): ch = CH_CB;
          BLK_IDX_W'(3): ch = CH_CR;
          default:       ch = CH_Y;
        endcase
      end
      MODE_420: begin
        case (blk_idx)
          BLK_IDX_W'(4): ch = CH_CB;
          BLK_IDX_W'(5): ch = CH_CR;
          default:       ch = CH_Y;
        endcase
      end
      default: ch = CH_Y;
    endcase
  end

  assign last_blk = (blk_idx == (nblk - BLK_IDX_W'(1)));

endmodule

// File: rtl/mcu_scheduler.sv
// Steps the entropy decoder through the blocks of each MCU, counts MCUs and
// handles restart intervals (marker skip followed by a DC predictor clear).
module mcu_scheduler
  import mcu_scheduler_pkg::*;
#(
  parameter int CH        = 3,
  parameter int MCU_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  input  logic [1:0]                cfg_mode,
  input  logic [MCU_CNT_W-1:0]      cfg_total_mcus,
  input  logic [MCU_CNT_W-1:0]      cfg_restart_int,
  input  logic                      block_done,
  input  logic                      marker_ack,
  output logic                      decode_en,
  output logic [$clog2(CH+1)-1:0]   ch,
  output logic [2:0]                blk_idx,
  output logic [MCU_CNT_W-1:0]      mcu_count,
  output logic                      marker_req,
  output logic                      dc_clear,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      err
);

  localparam int CH_W = $clog2(CH+1);

  sched_state_e             state_q, state_d;
  samp_mode_e               mode_q, mode_d;
  logic [MCU_CNT_W-1:0]     total_q, total_d;
  logic [MCU_CNT_W-1:0]     rint_q, rint_d;
  logic [MCU_CNT_W-1:0]     mcu_cnt_q, mcu_cnt_d;
  logic [MCU_CNT_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [BLK_IDX_W-1:0]     blk_idx_q, blk_idx_d;
  logic                     err_q, err_d;

  logic [CH_W-1:0]          lut_ch;
  logic [BLK_IDX_W-1:0]     lut_nblk;
  logic                     lut_last;
  logic [MCU_CNT_W-1:0]     mcu_cnt_inc;
  logic [MCU_CNT_W-1:0]     rst_cnt_inc;

  mcu_order_lut #(.CH_W(CH_W)) u_lut (
    .mode     (mode_q),
    .blk_idx  (blk_idx_q),
    .ch       (lut_ch),
    .nblk     (lut_nblk),
    .last_blk (lut_last)
  );

  assign mcu_cnt_inc = mcu_cnt_q + MCU_CNT_W'(1);
  assign rst_cnt_inc = rst_cnt_q + MCU_CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_GRAY;
      total_q   <= '0;
      rint_q    <= '0;
      mcu_cnt_q <= '0;
      rst_cnt_q <= '0;
      blk_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      total_q   <= total_d;
      rint_q    <= rint_d;
      mcu_cnt_q <= mcu_cnt_d;
      rst_cnt_q <= rst_cnt_d;
      blk_idx_q <= blk_idx_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    total_d    = total_q;
    rint_d     = rint_q;
    mcu_cnt_d  = mcu_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    blk_idx_d  = blk_idx_q;
    err_d      = err_q;
    decode_en  = 1'b0;
    marker_req = 1'b0;
    dc_clear   = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          mode_d  = samp_mode_e'(cfg_mode);
          total_d = cfg_total_mcus;
          rint_d  = cfg_restart_int;
          if (cfg_total_mcus == '0) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            dc_clear  = 1'b1;
            mcu_cnt_d = '0;
            rst_cnt_d = '0;
            blk_idx_d = '0;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        decode_en = 1'b1;
        if (block_done) begin
          if (!lut_last) begin
            blk_idx_d = blk_idx_q + BLK_IDX_W'(1);
          end else begin
            blk_idx_d = '0;
            mcu_cnt_d = mcu_cnt_inc;
            rst_cnt_d = rst_cnt_inc;
            // Frame end takes priority, so an interval landing on the last MCU never restarts.
            if (mcu_cnt_inc == total_q) begin
              state_d = ST_DONE;
            end else if (rint_q != '0 && rst_cnt_inc == rint_q) begin
              rst_cnt_d = '0;
              state_d   = ST_RESTART;
            end
          end
        end
      end
      ST_RESTART: begin
        marker_req = 1'b1;
        if (marker_ack) state_d = ST_DCCLR;
      end
      ST_DCCLR: begin
        dc_clear = 1'b1;
        state_d  = ST_RUN;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (block_done && state_q != ST_RUN) err_d = 1'b1;
  end

  assign ch        = lut_ch;
  assign blk_idx   = blk_idx_q;
  assign mcu_count = mcu_cnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule
